// File: rtl/tile_sched.sv
// tile_sched: walks a frame as a raster of TILE x TILE windows, launches one
// cache fill per window, and hands each filled cache to the processing engine
// through a valid/done handshake. A per-window watchdog aborts stuck fills.
module tile_sched #(
    parameter int IM_WIDTH  = 480,
    parameter int IM_HEIGHT = 640,
    parameter int TILE      = 32,
    parameter int TIMEOUT   = 4096
) (
    input  logic        p_clk,
    input  logic        preset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] frame_addr,
    input  logic [31:0] org_x,
    input  logic [31:0] org_y,
    output logic [31:0] im_addr_I,
    output logic [31:0] cache_x_in,
    output logic [31:0] cache_y_in,
    output logic        init_ok,
    input  logic        cache_rdy,
    output logic        tile_valid,
    input  logic        tile_done,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err,
    output logic [15:0] tile_cnt
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic signed [31:0] TILE_S  = 32'(TILE);
    localparam logic signed [31:0] TILE_M1 = 32'(TILE - 1);
    localparam logic signed [31:0] W_S     = 32'(IM_WIDTH);
    localparam logic signed [31:0] H_S     = 32'(IM_HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LAUNCH,
        S_WAIT_FILL,
        S_PRESENT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic signed [31:0] x, y;
    logic signed [31:0] ox, oy;
    logic signed [31:0] x_step, y_step;
    logic               row_wrap;
    logic               outside;
    logic               fill_ok;
    logic               wd_expired;
    logic               armed;
    logic [WD_W-1:0]    wdog;

    // Raster stepping and window classification from the current position.
    always_comb begin
        x_step     = x + TILE_S;
        row_wrap   = (x_step >= W_S);
        y_step     = row_wrap ? (y + TILE_S) : y;
        outside    = ((x + TILE_M1) < 0) || ((y + TILE_M1) < 0);
        fill_ok    = cache_rdy && armed;
        wd_expired = (wdog == WD_LAST);
    end

    // State register.
    always_ff @(posedge p_clk or negedge preset_n) begin
        if (!preset_n) state <= S_IDLE;
        else           state <= state_nx;
    end

    // Next-state and Moore outputs; abort overrides every transition.
    always_comb begin
        state_nx   = state;
        init_ok    = 1'b0;
        tile_valid = 1'b0;
        frame_done = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE:      if (start) state_nx = S_CHECK;
            S_CHECK:     state_nx = outside ? S_NEXT : S_LAUNCH;
            S_LAUNCH: begin
                init_ok  = 1'b1;
                state_nx = S_WAIT_FILL;
            end
            S_WAIT_FILL: begin
                if (fill_ok)         state_nx = S_PRESENT;
                else if (wd_expired) state_nx = S_IDLE;
            end
            S_PRESENT: begin
                tile_valid = 1'b1;
                if (tile_done) state_nx = S_NEXT;
            end
            S_NEXT:      state_nx = (y_step >= H_S) ? S_DONE : S_CHECK;
            S_DONE: begin
                frame_done = 1'b1;
                state_nx   = S_IDLE;
            end
            default:     state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    // Datapath: latched frame parameters, raster position, fill tracking, counters.
    // Window coordinates are loaded on the CHECK->LAUNCH edge so they are already
    // valid during the init_ok cycle and stay put until the next launch.
    always_ff @(posedge p_clk or negedge preset_n) begin
        if (!preset_n) begin
            im_addr_I   <= '0;
            cache_x_in  <= '0;
            cache_y_in  <= '0;
            ox          <= '0;
            oy          <= '0;
            x           <= '0;
            y           <= '0;
            armed       <= 1'b0;
            wdog        <= '0;
            tile_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (!abort) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        im_addr_I   <= frame_addr;
                        ox          <= org_x;
                        oy          <= org_y;
                        x           <= org_x;
                        y           <= org_y;
                        tile_cnt    <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (!outside) begin
                        cache_x_in <= x;
                        cache_y_in <= y;
                    end
                end
                S_LAUNCH: begin
                    armed <= 1'b0;
                    wdog  <= '0;
                end
                S_WAIT_FILL: begin
                    if (!cache_rdy) armed <= 1'b1;
                    wdog <= wdog + 1'b1;
                    if (!fill_ok && wd_expired) timeout_err <= 1'b1;
                end
                S_PRESENT: begin
                    if (tile_done && (tile_cnt != '1)) tile_cnt <= tile_cnt + 16'd1;
                end
                S_NEXT: begin
                    x <= row_wrap ? ox : x_step;
                    y <= y_step;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_sched.sv
// Directed testbench for tile_sched: reset values, launch timing, stale-ready
// rejection, abort, watchdog, reset mid-fill, full frame and negative origin.
module tb_tile_sched;

    localparam int TO = 4096;

    logic        p_clk = 1'b0;
    logic        preset_n;
    logic        start, abort;
    logic [31:0] frame_addr, org_x, org_y;
    logic [31:0] im_addr_I, cache_x_in, cache_y_in;
    logic        init_ok, cache_rdy, tile_valid, tile_done;
    logic        busy, frame_done, timeout_err;
    logic [15:0] tile_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int fd_total = 0;

    int          launches, row0, far_left, fd_before;
    logic [31:0] fx, fy;
    logic        fd_busy, hung;

    tile_sched #(
        .IM_WIDTH (480),
        .IM_HEIGHT(640),
        .TILE     (32),
        .TIMEOUT  (TO)
    ) dut (
        .p_clk      (p_clk),
        .preset_n   (preset_n),
        .start      (start),
        .abort      (abort),
        .frame_addr (frame_addr),
        .org_x      (org_x),
        .org_y      (org_y),
        .im_addr_I  (im_addr_I),
        .cache_x_in (cache_x_in),
        .cache_y_in (cache_y_in),
        .init_ok    (init_ok),
        .cache_rdy  (cache_rdy),
        .tile_valid (tile_valid),
        .tile_done  (tile_done),
        .busy       (busy),
        .frame_done (frame_done),
        .timeout_err(timeout_err),
        .tile_cnt   (tile_cnt)
    );

    always #5 p_clk = ~p_clk;

    // Counts frame_done pulses over the whole run.
    always @(negedge p_clk) if (frame_done) fd_total++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_init_ok"}, init_ok, 0);
        check_eq({tag, "_tile_valid"}, tile_valid, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_frame_done"}, frame_done, 0);
        check_eq({tag, "_timeout_err"}, timeout_err, 0);
        check_eq({tag, "_tile_cnt"}, tile_cnt, 0);
        check_eq({tag, "_cache_x"}, cache_x_in, 0);
        check_eq({tag, "_cache_y"}, cache_y_in, 0);
        check_eq({tag, "_im_addr"}, im_addr_I, 0);
    endtask

    // Runs one frame with a fill responder (cache_rdy pulse 10 cycles after
    // init_ok) and a consumer (tile_done one cycle after tile_valid).
    task automatic run_frame(input logic [31:0] ox, input logic [31:0] oy);
        int   cd;
        logic tv_prev;
        logic first;
        cd = 0; tv_prev = 0; first = 1;
        launches = 0; row0 = 0; far_left = 0; fd_busy = 0; hung = 1;
        fx = '0; fy = '0;
        @(negedge p_clk);
        org_x = ox; org_y = oy; frame_addr = 32'h0800_0000; start = 1;
        @(negedge p_clk);
        start = 0;
        for (int c = 0; c < 20000; c++) begin
            if (!busy) begin
                hung = 0;
                break;
            end
            cache_rdy = 0;
            tile_done = 0;
            if (init_ok) begin
                launches++;
                if (first) begin
                    fx = cache_x_in; fy = cache_y_in; first = 0;
                end
                if (cache_y_in == 32'd0) row0++;
                if ($signed(cache_x_in) < -31) far_left++;
                cd = 10;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) cache_rdy = 1;
            end
            if (tile_valid && tv_prev) tile_done = 1;
            tv_prev = tile_valid;
            if (frame_done) fd_busy = busy;
            @(negedge p_clk);
        end
        cache_rdy = 0;
        tile_done = 0;
    endtask

    initial begin
        preset_n = 0; start = 0; abort = 0; cache_rdy = 0; tile_done = 0;
        frame_addr = '0; org_x = '0; org_y = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge p_clk);
        preset_n = 1;

        // Start-to-launch latency, then stale ready level held across LAUNCH.
        @(negedge p_clk);
        frame_addr = 32'hA000_0000; org_x = 0; org_y = 0; start = 1; cache_rdy = 1;
        @(negedge p_clk);
        start = 0;
        check_eq("start_busy", busy, 1);
        check_eq("check_no_launch", init_ok, 0);
        @(negedge p_clk);
        check_eq("launch_pulse", init_ok, 1);
        check_eq("launch_x", cache_x_in, 0);
        check_eq("launch_addr", im_addr_I, 32'hA000_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge p_clk);
            check_eq("stale_ready_ignored", tile_valid, 0);
        end
        check_eq("launch_single", init_ok, 0);
        // start while busy and stray tile_done must both be ignored
        start = 1; org_x = 32'd123; tile_done = 1; cache_rdy = 0;
        @(negedge p_clk);
        start = 0; tile_done = 0;
        check_eq("low_no_present", tile_valid, 0);
        check_eq("busy_start_ign", cache_x_in, 0);
        check_eq("stray_done_ign", tile_cnt, 0);
        cache_rdy = 1;
        @(negedge p_clk);
        check_eq("rerise_present", tile_valid, 1);
        cache_rdy = 0;
        repeat (3) @(negedge p_clk);
        check_eq("present_hold", tile_valid, 1);

        // Abort during PRESENT.
        abort = 1;
        @(negedge p_clk);
        abort = 0;
        check_eq("abort_valid", tile_valid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_no_fd", fd_total, 0);

        // start together with abort is dropped.
        start = 1; abort = 1; org_x = 32'd64; org_y = 32'd96; frame_addr = 32'h1234_0000;
        @(negedge p_clk);
        abort = 0;
        check_eq("start_abort_idle", busy, 0);
        @(negedge p_clk);
        start = 0;
        check_eq("restart_busy", busy, 1);
        @(negedge p_clk);
        check_eq("restart_launch", init_ok, 1);
        check_eq("restart_x", cache_x_in, 32'd64);
        check_eq("restart_y", cache_y_in, 32'd96);
        check_eq("restart_addr", im_addr_I, 32'h1234_0000);
        @(negedge p_clk);
        cache_rdy = 0;
        @(negedge p_clk);
        cache_rdy = 1;
        @(negedge p_clk);
        cache_rdy = 0;
        check_eq("fresh_present", tile_valid, 1);
        tile_done = 1;
        @(negedge p_clk);
        tile_done = 0;
        check_eq("done_drops_valid", tile_valid, 0);
        check_eq("tile_cnt_one", tile_cnt, 1);
        abort = 1;
        @(negedge p_clk);
        abort = 0;
        check_eq("abort2_busy", busy, 0);
        check_eq("abort_keeps_cnt", tile_cnt, 1);

        // Watchdog: cache_rdy stuck low.
        fd_before = fd_total;
        org_x = 0; org_y = 0; start = 1;
        @(negedge p_clk);
        start = 0;
        @(negedge p_clk);
        check_eq("wd_launch", init_ok, 1);
        repeat (TO) @(negedge p_clk);
        check_eq("wd_not_yet", timeout_err, 0);
        check_eq("wd_busy_before", busy, 1);
        @(negedge p_clk);
        check_eq("wd_err", timeout_err, 1);
        check_eq("wd_idle", busy, 0);
        check_eq("wd_no_fd", fd_total - fd_before, 0);
        repeat (2) @(negedge p_clk);
        check_eq("wd_sticky", timeout_err, 1);

        // A new start clears the error; then reset lands mid-fill.
        org_x = 32'd32; org_y = 32'd64; frame_addr = 32'h5555_0000; start = 1;
        @(negedge p_clk);
        start = 0;
        check_eq("start_clears_err", timeout_err, 0);
        @(negedge p_clk);
        check_eq("rst_pre_launch_x", cache_x_in, 32'd32);
        repeat (2) @(negedge p_clk);
        #2 preset_n = 0;
        #1;
        check_reset_outputs("midfill_reset");
        @(negedge p_clk);
        preset_n = 1;

        // Full frame from origin after reset.
        fd_before = fd_total;
        run_frame(32'd0, 32'd0);
        @(negedge p_clk);
        check_eq("full_finished", hung, 0);
        check_eq("full_launches", launches, 300);
        check_eq("full_tile_cnt", tile_cnt, 300);
        check_eq("full_frame_done", fd_total - fd_before, 1);
        check_eq("full_fd_busy", fd_busy, 1);
        check_eq("full_first_x", fx, 0);
        check_eq("full_row0", row0, 15);

        // Negative origin: window at x=-40 is skipped.
        fd_before = fd_total;
        run_frame(-32'sd40, 32'd0);
        @(negedge p_clk);
        check_eq("neg_finished", hung, 0);
        check_eq("neg_first_x", fx, -32'sd8);
        check_eq("neg_first_y", fy, 0);
        check_eq("neg_row0", row0, 16);
        check_eq("neg_skipped", far_left, 0);
        check_eq("neg_launches", launches, 320);
        check_eq("neg_tile_cnt", tile_cnt, 320);
        check_eq("neg_frame_done", fd_total - fd_before, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tile_sched.md
# tile_sched

Tile scheduler for the video_in cache path. It walks a frame as a raster of TILE×TILE windows starting from a signed origin. For each window it launches one cache fill through the cache-window calculator (`init_ok` / `cache_x_in` / `cache_y_in` / `cache_rdy`) and hands the filled cache to the downstream processing engine with a valid/done handshake. Windows lying entirely above or left of the image are skipped. A watchdog aborts the frame if a fill never completes.

## Interface
- IM_WIDTH, 480, image width in pixels
- IM_HEIGHT, 640, image height in lines
- TILE, 32, window edge in pixels; equals the cache DATA_SIZE
- TIMEOUT, 4096, maximum cycles to wait for `cache_rdy` per window
- p_clk  in  1  clock, rising edge
- preset_n  in  1  asynchronous reset, active-low
- start  in  1  frame start request; accepted only in IDLE
- abort  in  1  synchronous abort; wins over every other input
- frame_addr  in  32  frame base address, latched at start
- org_x, org_y  in  32  signed first-window origin, latched at start
- im_addr_I  out  32  latched frame_addr, sent to the calculator
- cache_x_in, cache_y_in  out  32  signed current window origin
- init_ok  out  1  one-cycle launch pulse to the calculator
- cache_rdy  in  1  fill-complete level from the calculator
- tile_valid  out  1  current cache contents are ready for the engine
- tile_done  in  1  engine has finished with the current cache
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at the end of a normal frame
- timeout_err  out  1  sticky error flag; cleared by the next accepted start
- tile_cnt  out  16  windows presented in the current frame

## Operation
- States: IDLE, CHECK, LAUNCH, WAIT_FILL, PRESENT, NEXT, DONE.
- **IDLE**, on start:
  - latch frame_addr, org_x, org_y;
  - set x=org_x, y=org_y;
  - clear tile_cnt and timeout_err;
  - go to CHECK.
- **CHECK:** if x+TILE-1<0 or y+TILE-1<0, the window is fully outside; go to NEXT with no launch. Otherwise go to LAUNCH.
- **LAUNCH:** init_ok=1 for exactly this cycle, with cache_x_in=x and cache_y_in=y. Clear the armed flag and the watchdog. Go to WAIT_FILL.
- **WAIT_FILL:**
  - cache_rdy low sets armed.
  - cache_rdy high while armed goes to PRESENT. A stale high level left over from the previous fill is therefore ignored.
  - The watchdog increments every cycle. When it reaches TIMEOUT-1, set timeout_err and go to IDLE with no frame_done.
- **PRESENT:** tile_valid=1. When tile_done=1, increment tile_cnt and go to NEXT. tile_done outside PRESENT is ignored.
- **NEXT:**
  - x += TILE.
  - If the new x >= IM_WIDTH: x=org_x and y += TILE.
  - If y >= IM_HEIGHT: go to DONE; otherwise go to CHECK.
- **DONE:** frame_done=1 for one cycle, then go to IDLE.
- **abort:** from any state, go to IDLE on the next edge. init_ok and tile_valid are low from that edge; no frame_done is generated. tile_cnt keeps its value.
- **Arithmetic:** x and y are 32-bit signed. Comparisons against IM_WIDTH and IM_HEIGHT are signed. The watchdog counter is $clog2(TIMEOUT) bits wide. tile_cnt saturates at 16'hFFFF.
- cache_x_in, cache_y_in and im_addr_I are held stable from LAUNCH through the exit from PRESENT.

## Timing
- **Reset values:** state=IDLE, init_ok=0, tile_valid=0, busy=0, frame_done=0, timeout_err=0, tile_cnt=0, cache_x_in=0, cache_y_in=0, im_addr_I=0.
- **Start to launch:** start high in IDLE at edge n → CHECK at n+1 → init_ok high during cycle n+2.
- **Skipped window:** costs 2 cycles (CHECK, NEXT).
- **Fill to present:** armed rising of cache_rdy sampled at edge m → tile_valid high from m+1.
- **Consumer handshake:** tile_done sampled at edge k in PRESENT → tile_valid low from k+1; the next init_ok is at k+3 at the earliest.
- **Frame end:** frame_done is high the cycle after the last NEXT; busy falls one cycle after frame_done.
- **start during busy:** ignored.
- **start and abort in the same cycle:** abort wins.

## Test plan
- **Full frame:** org=(0,0), 480×640, TILE=32, cache_rdy pulsing 10 cycles after each init_ok, tile_done 1 cycle after tile_valid → 300 init_ok pulses, tile_cnt=300, exactly one frame_done.
- **Negative origin:** org=(-40,0) → window x=-40 skipped (no init_ok); first launch at (-8,0); each row has 16 launches.
- **Stale ready:** cache_rdy held high across LAUNCH, dropped 1 cycle, then raised → exactly one PRESENT entry, only after the re-rise.
- **Watchdog:** cache_rdy stuck low → timeout_err=1 exactly TIMEOUT cycles after entering WAIT_FILL; no frame_done; busy=0.
- **Abort during PRESENT:** abort with tile_valid=1 → tile_valid=0 next cycle; a following start relaunches at org.
- **Reset mid-fill:** preset_n low during WAIT_FILL → all outputs at reset values immediately; start after release behaves like a first frame.
